instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 201 ++++++++++++++++++++
 tb/tb_instr_mem_loader.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// ----------------------------------------------------------------------------
// instr_mem_loader
//
// Streams bytes from a byte-wide source into a 32-bit instruction memory.
// A load is requested with a one-cycle start pulse carrying a byte start
// address and a word count. Bytes are packed little-endian into words, and
// each completed word is written with a single-cycle mem_we strobe. The
// request is range-checked against DEPTH before any write takes place.
//
// Build option:
//   LOADER_CHECKSUM_EN  defined   -> checksum accumulates every written word
//                       undefined -> checksum tied to 0, no adder
//
// Parameters:
//   DEPTH       instruction memory depth in 32-bit words
//   CNT_W       width of word_count
//
// Ports:
//   clk         clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle load request, honoured only when idle
//   base_addr   byte start address (bits [1:0] ignored)
//   word_count  number of words to load
//   byte_valid  source presents a byte
//   byte_data   byte payload
//   byte_ready  loader takes a byte this cycle
//   mem_we      memory write strobe, one cycle per word
//   mem_addr    word-aligned byte address of the write
//   mem_wdata   word to write
//   busy        load in progress (through the done cycle)
//   done        one-cycle end-of-request pulse
//   err         sticky: last request was rejected
//   checksum    running sum of written words
// ----------------------------------------------------------------------------
// state    | meaning
// ---------+------------------------------------------------------------------
// IDLE     | waiting for start; range-checks the request
// COLLECT  | taking bytes from the source until four are packed
// WRITE    | one-cycle memory write of the packed word
// FIN      | one-cycle done pulse, then back to IDLE
// ----------------------------------------------------------------------------
module instr_mem_loader #(
   parameter int DEPTH = 1024,
   parameter int CNT_W = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      base_addr,
   input  logic [CNT_W-1:0] word_count,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             mem_we,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [31:0]      checksum
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_FIN     = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [1:0]       lane;
   logic [31:0]      word_buf;
   logic [CNT_W-1:0] words_left;
   logic [31:0]      addr_q;
   logic             err_q;

   logic [32:0]      end_word;
   logic             req_zero;
   logic             req_bad;
   logic             start_go;
   logic             load_go;
   logic             xfer;
   logic             last_word;

   // One word past the last word touched by the request; 33 bits so the
   // sum cannot wrap before it is compared against DEPTH.
   assign end_word  = (33'(base_addr) >> 2) + 33'(word_count);
   assign req_zero  = (word_count == '0);
   assign req_bad   = (33'(word_count) > 33'(DEPTH)) || (end_word > 33'(DEPTH));

   assign start_go  = (state == S_IDLE) && start;
   assign load_go   = start_go && !req_bad && !req_zero;
   assign xfer      = byte_ready && byte_valid;

   // words_left counts down from word_count; the word being written is the
   // last one when only it remains.
   assign last_word = (words_left == CNT_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (req_bad || req_zero) begin
                  state_nxt = S_FIN;
               end else begin
                  state_nxt = S_COLLECT;
               end
            end
         end
         S_COLLECT: begin
            byte_ready = 1'b1;
            if (byte_valid && (lane == 2'd3)) begin
               state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            mem_we = 1'b1;
            if (last_word) begin
               state_nxt = S_FIN;
            end else begin
               state_nxt = S_COLLECT;
            end
         end
         S_FIN: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane       <= '0;
         word_buf   <= '0;
         words_left <= '0;
         addr_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         // Any start taken in IDLE updates err: rejected sets, others clear.
         if (start_go) begin
            err_q <= req_bad;
         end
         if (load_go) begin
            addr_q     <= base_addr & ~32'd3;
            words_left <= word_count;
            lane       <= '0;
         end
         // Shift in from the top: after four bytes the first one has
         // reached [7:0], giving little-endian packing without lane muxing.
         if (xfer) begin
            word_buf <= {byte_data, word_buf[31:8]};
            lane     <= lane + 2'd1;
         end
         if (state == S_WRITE) begin
            words_left <= words_left - CNT_W'(1);
            addr_q     <= addr_q + 32'd4;
         end
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = word_buf;
   assign busy      = (state != S_IDLE);
   assign err       = err_q;

`ifdef LOADER_CHECKSUM_EN
   logic [31:0] csum_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum_q <= '0;
      end else if (start_go && !req_bad) begin
         csum_q <= '0;
      end else if (mem_we) begin
         csum_q <= csum_q + word_buf;
      end
   end

   assign checksum = csum_q;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

   localparam int DEPTH = 1024;
   localparam int CNT_W = 11;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [31:0]      base_addr;
   logic [CNT_W-1:0] word_count;
   logic             byte_valid;
   logic [7:0]       byte_data;
   logic             byte_ready;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wdata;
   logic             busy;
   logic             done;
   logic             err;
   logic [31:0]      checksum;

   int checks;
   int failures;

   int          cyc_n;
   int          wr_n;
   int          rdy_n;
   logic [31:0] wr_addr [16];
   logic [31:0] wr_data [16];
   int          wr_cyc  [16];

   instr_mem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .checksum   (checksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc_n++;

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_we && wr_n < 16) begin
            wr_addr[wr_n] = mem_addr;
            wr_data[wr_n] = mem_wdata;
            wr_cyc[wr_n]  = cyc_n;
            wr_n++;
         end
         if (byte_ready) rdy_n++;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_n  = 0;
      rdy_n = 0;
   endtask

   task automatic do_start(input logic [31:0] b, input logic [CNT_W-1:0] wc);
      base_addr  = b;
      word_count = wc;
      start      = 1'b1;
      cyc();
      start      = 1'b0;
   endtask

   task automatic send_bytes(input logic [63:0] bytes, input int n, input bit toggle);
      for (int i = 0; i < n; i++) begin
         int k;
         k = 0;
         byte_data  = bytes[8*i +: 8];
         byte_valid = 1'b1;
         while (!byte_ready && k < 50) begin
            cyc();
            k++;
         end
         checks++;
         if (byte_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready_timeout byte=%0d got=%b exp=1", i, byte_ready);
         end
         cyc();
         if (toggle) begin
            byte_valid = 1'b0;
            cyc();
         end
      end
      byte_valid = 1'b0;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (done !== 1'b1 && k < 100) begin
         cyc();
         k++;
      end
      checks++;
      if (done !== 1'b1) begin
         failures++;
         $display("FAIL done_timeout got=%b exp=1", done);
      end
      cyc();
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      start      = 1'b1;
      base_addr  = 32'h0;
      word_count = '0;
      byte_valid = 1'b0;
      byte_data  = 8'h0;
      #23;
      checks++;
      if ({byte_ready, mem_we, busy, done, err} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=00000", {byte_ready, mem_we, busy, done, err});
      end
      checks++;
      if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_addr_data got=%h/%h exp=0/0", mem_addr, mem_wdata);
      end
      checks++;
      if (checksum !== 32'h0) begin
         failures++;
         $display("FAIL reset_checksum got=%h exp=0", checksum);
      end
      // start already high when reset releases: first edge must take it
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || err !== 1'b0) begin
         failures++;
         $display("FAIL reset_first_edge_start got=done%b err%b exp=done1 err0", done, err);
      end
      cyc();
   endtask

   task automatic test_two_words();
      clear_log();
      do_start(32'h0, 11'd2);
      checks++;
      if (busy !== 1'b1 || byte_ready !== 1'b1) begin
         failures++;
         $display("FAIL two_busy_ready got=%b%b exp=11", busy, byte_ready);
      end
      send_bytes(64'h00100093_00000013, 8, 1'b0);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h4 || mem_wdata !== 32'h00100093) begin
         failures++;
         $display("FAIL two_last_write got=we%b %h %h exp=we1 00000004 00100093",
                  mem_we, mem_addr, mem_wdata);
      end
      cyc();
      checks++;
      if (done !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL two_done_latency got=done%b we%b busy%b exp=done1 we0 busy1",
                  done, mem_we, busy);
      end
      cyc();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL two_idle got=done%b busy%b exp=00", done, busy);
      end
      checks++;
      if (wr_n !== 2) begin
         failures++;
         $display("FAIL two_write_count got=%0d exp=2", wr_n);
      end
      checks++;
      if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h00000013) begin
         failures++;
         $display("FAIL two_first_write got=%h %h exp=00000000 00000013", wr_addr[0], wr_data[0]);
      end
      checks++;
      if (wr_cyc[1] - wr_cyc[0] !== 5) begin
         failures++;
         $display("FAIL two_throughput got=%0d exp=5", wr_cyc[1] - wr_cyc[0]);
      end
`ifdef LOADER_CHECKSUM_EN
      checks++;
      if (checksum !== 32'h001000A6) begin
         failures++;
         $display("FAIL two_checksum got=%h exp=001000a6", checksum);
      end
`else
      checks++;
      if (checksum !== 32'h0) begin
         failures++;
         $display("FAIL two_checksum_off got=%h exp=0", checksum);
      end
`endif
   endtask

   task automatic test_zero_count();
      clear_log();
      do_start(32'h40, 11'd0);
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || mem_we !== 1'b0) begin
         failures++;
         $display("FAIL zero_done got=done%b err%b we%b exp=done1 err0 we0", done, err, mem_we);
      end
      cyc();
      cyc();
      checks++;
      if (wr_n !== 0 || rdy_n !== 0 || done !== 1'b0) begin
         failures++;
         $display("FAIL zero_quiet got=wr%0d rdy%0d done%b exp=0 0 0", wr_n, rdy_n, done);
      end
   endtask

   task automatic test_range_err();
      clear_log();
      do_start(32'hFFC, 11'd2);
      checks++;
      if (done !== 1'b1 || err !== 1'b1) begin
         failures++;
         $display("FAIL range_reject got=done%b err%b exp=done1 err1", done, err);
      end
      cyc();
      checks++;
      if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL range_sticky got=err%b done%b busy%b exp=100", err, done, busy);
      end
      do_start(32'h0, 11'd1025);
      checks++;
      if (done !== 1'b1 || err !== 1'b1) begin
         failures++;
         $display("FAIL range_count got=done%b err%b exp=11", done, err);
      end
      cyc();
      checks++;
      if (wr_n !== 0) begin
         failures++;
         $display("FAIL range_no_write got=%0d exp=0", wr_n);
      end
      // last word of memory exactly: accepted, clears err
      do_start(32'hFFC, 11'd1);
      checks++;
      if (err !== 1'b0 || byte_ready !== 1'b1) begin
         failures++;
         $display("FAIL range_edge_accept got=err%b rdy%b exp=err0 rdy1", err, byte_ready);
      end
      send_bytes(64'hDDCCBBAA, 4, 1'b0);
      wait_done();
      checks++;
      if (wr_n !== 1 || wr_addr[0] !== 32'hFFC || wr_data[0] !== 32'hDDCCBBAA) begin
         failures++;
         $display("FAIL range_edge_write got=n%0d %h %h exp=1 00000ffc ddccbbaa",
                  wr_n, wr_addr[0], wr_data[0]);
      end
`ifdef LOADER_CHECKSUM_EN
      checks++;
      if (checksum !== 32'hDDCCBBAA) begin
         failures++;
         $display("FAIL range_checksum got=%h exp=ddccbbaa", checksum);
      end
`endif
   endtask

   task automatic test_stall();
      clear_log();
      do_start(32'h13, 11'd1);
      send_bytes(64'h44332211, 4, 1'b1);
      wait_done();
      checks++;
      if (wr_n !== 1 || wr_addr[0] !== 32'h10 || wr_data[0] !== 32'h44332211) begin
         failures++;
         $display("FAIL stall_write got=n%0d %h %h exp=1 00000010 44332211",
                  wr_n, wr_addr[0], wr_data[0]);
      end
   endtask

   task automatic test_restart_ignored();
      clear_log();
      do_start(32'h200, 11'd2);
      send_bytes(64'h01, 1, 1'b0);
      base_addr  = 32'h0;
      word_count = 11'd5;
      start      = 1'b1;
      cyc();
      start      = 1'b0;
      send_bytes(64'h0008070605040302, 7, 1'b0);
      wait_done();
      repeat (5) cyc();
      checks++;
      if (wr_n !== 2 || busy !== 1'b0) begin
         failures++;
         $display("FAIL restart_count got=n%0d busy%b exp=2 0", wr_n, busy);
      end
      checks++;
      if (wr_addr[0] !== 32'h200 || wr_data[0] !== 32'h04030201 ||
          wr_addr[1] !== 32'h204 || wr_data[1] !== 32'h08070605) begin
         failures++;
         $display("FAIL restart_writes got=%h %h %h %h exp=00000200 04030201 00000204 08070605",
                  wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
      end
   endtask

   task automatic test_reset_mid();
      clear_log();
      do_start(32'h20, 11'd2);
      send_bytes(64'h0201, 2, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({byte_ready, mem_we, busy, done, err} !== 5'b0 ||
          mem_addr !== 32'h0 || mem_wdata !== 32'h0 || checksum !== 32'h0) begin
         failures++;
         $display("FAIL midreset_async got=%b %h %h %h exp=00000 0 0 0",
                  {byte_ready, mem_we, busy, done, err}, mem_addr, mem_wdata, checksum);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      clear_log();
      repeat (10) cyc();
      checks++;
      if (wr_n !== 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL midreset_no_write got=n%0d busy%b exp=0 0", wr_n, busy);
      end
      do_start(32'h30, 11'd1);
      send_bytes(64'hDEADBEEF, 4, 1'b0);
      wait_done();
      checks++;
      if (wr_n !== 1 || wr_addr[0] !== 32'h30 || wr_data[0] !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL midreset_reload got=n%0d %h %h exp=1 00000030 deadbeef",
                  wr_n, wr_addr[0], wr_data[0]);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc_n    = 0;
      wr_n     = 0;
      rdy_n    = 0;
      test_reset();
      test_two_words();
      test_zero_count();
      test_range_err();
      test_stall();
      test_restart_ignored();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
